// File: rtl/field_cfg_dumper_if.sv
// Byte stream link between the field dumper and its sink.
// The dumper drives o_data/o_valid; the sink drives i_ready.
interface field_cfg_dumper_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/field_cfg_dumper.sv
// Field configuration dumper: scans the field in raster order through a
// 1-cycle read port, packs 8 cells per byte LSB first and streams the bytes out.
module field_cfg_dumper #(
    parameter int FIELD_W    = 5,
    parameter int FIELD_H    = 3,
    parameter int X_ADR_SIZE = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
    parameter int Y_ADR_SIZE = (FIELD_H > 1) ? $clog2(FIELD_H) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_go,
    output logic                  o_is_dumping,
    output logic                  o_rd_en,
    output logic [X_ADR_SIZE-1:0] o_rd_x,
    output logic [Y_ADR_SIZE-1:0] o_rd_y,
    input  logic                  i_rd_cell,
    output logic                  o_done,
    field_cfg_dumper_if.master    stream
);

    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_EMIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  state_q;
    logic [X_ADR_SIZE-1:0]   x_q;
    logic [Y_ADR_SIZE-1:0]   y_q;
    logic [2:0]              bit_q;
    logic [7:0]              shift_q;
    logic                    rd_en_q;
    logic                    valid_q;
    logic                    done_q;
    logic                    dumping_q;

    logic [X_ADR_SIZE-1:0]   x_d;
    logic [Y_ADR_SIZE-1:0]   y_d;
    logic                    last_cell_s;
    logic [7:0]              shift_cap_s;

    // Next raster address, last-cell flag and shift register with the current cell merged in.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        last_cell_s = (x_q == X_LAST) && (y_q == Y_LAST);
        shift_cap_s = shift_q;
        shift_cap_s[bit_q] = i_rd_cell;
        if (x_q == X_LAST) begin
            x_d = {X_ADR_SIZE{1'b0}};
            y_d = y_q + Y_ADR_SIZE'(1);
        end else begin
            x_d = x_q + X_ADR_SIZE'(1);
            y_d = y_q;
        end
    end

    // Scan FSM; every output is a register set on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= {X_ADR_SIZE{1'b0}};
            y_q       <= {Y_ADR_SIZE{1'b0}};
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            rd_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            dumping_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (i_go) begin
                        x_q       <= {X_ADR_SIZE{1'b0}};
                        y_q       <= {Y_ADR_SIZE{1'b0}};
                        bit_q     <= 3'd0;
                        shift_q   <= 8'd0;
                        rd_en_q   <= 1'b1;
                        dumping_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    shift_q <= shift_cap_s;
                    if ((bit_q == 3'd7) || last_cell_s) begin
                        valid_q <= 1'b1;
                        state_q <= S_EMIT;
                    end else begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        bit_q   <= bit_q + 3'd1;
                        rd_en_q <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_EMIT: begin
                    // Byte and valid stay frozen until the sink takes them.
                    if (stream.i_ready) begin
                        valid_q <= 1'b0;
                        if (last_cell_s) begin
                            done_q    <= 1'b1;
                            dumping_q <= 1'b0;
                            state_q   <= S_DONE;
                        end else begin
                            x_q     <= x_d;
                            y_q     <= y_d;
                            bit_q   <= 3'd0;
                            shift_q <= 8'd0;
                            rd_en_q <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end else begin
                        state_q <= S_EMIT;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    rd_en_q   <= 1'b0;
                    valid_q   <= 1'b0;
                    done_q    <= 1'b0;
                    dumping_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_is_dumping   = dumping_q;
    assign o_rd_en        = rd_en_q;
    assign o_rd_x         = x_q;
    assign o_rd_y         = y_q;
    assign o_done         = done_q;
    assign stream.o_data  = shift_q;
    assign stream.o_valid = valid_q;

endmodule

// File: tb/tb_field_cfg_dumper.sv
// Directed bench for field_cfg_dumper: a 5x3 instance driven from a vector
// table plus reset/re-trigger sequences, and an 8x2 instance for the N%8==0 case.
module tb_field_cfg_dumper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- 5x3 instance ----------------
    logic        go_a = 1'b0;
    logic        a_dump, a_rd_en, a_done;
    logic [2:0]  a_x;
    logic [1:0]  a_y;
    logic        a_cell = 1'b0;
    logic [14:0] mem_a = 15'd0;
    field_cfg_dumper_if a_if ();

    field_cfg_dumper #(.FIELD_W(5), .FIELD_H(3)) dut_a (
        .clk(clk), .rst(rst), .i_go(go_a), .o_is_dumping(a_dump),
        .o_rd_en(a_rd_en), .o_rd_x(a_x), .o_rd_y(a_y), .i_rd_cell(a_cell),
        .o_done(a_done), .stream(a_if)
    );

    // ---------------- 8x2 instance ----------------
    logic        go_b = 1'b0;
    logic        b_dump, b_rd_en, b_done;
    logic [2:0]  b_x;
    logic [0:0]  b_y;
    logic        b_cell = 1'b0;
    logic [15:0] mem_b = 16'hFFFF;
    field_cfg_dumper_if b_if ();

    field_cfg_dumper #(.FIELD_W(8), .FIELD_H(2)) dut_b (
        .clk(clk), .rst(rst), .i_go(go_b), .o_is_dumping(b_dump),
        .o_rd_en(b_rd_en), .o_rd_x(b_x), .o_rd_y(b_y), .i_rd_cell(b_cell),
        .o_done(b_done), .stream(b_if)
    );

    // Field memories with one cycle of read latency
    always @(posedge clk) begin
        a_cell <= (a_rd_en && (int'(a_y) * 5 + int'(a_x) < 15)) ? mem_a[int'(a_y) * 5 + int'(a_x)] : 1'b0;
        b_cell <= b_rd_en ? mem_b[int'(b_y) * 8 + int'(b_x)] : 1'b0;
    end

    typedef struct {
        logic [14:0] pat;
        int          stall;
        bit          go_mid;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_a(input vec_t v);
        int strobes;
        int nbytes;
        int stall_left;
        bit fin;
        logic [7:0] exp_b;
        strobes    = 0;
        nbytes     = 0;
        stall_left = v.stall;
        fin        = 1'b0;
        mem_a      = v.pat;
        a_if.i_ready = 1'b1;
        @(negedge clk); go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        chk("is_dumping_start", 32'(a_dump), 32'd1);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            go_a = v.go_mid && (cyc == 5 || cyc == 12);
            if (a_rd_en) begin
                chk("rd_x", 32'(a_x), 32'(strobes % 5));
                chk("rd_y", 32'(a_y), 32'(strobes / 5));
                strobes++;
            end
            if (a_if.o_valid) begin
                exp_b = (nbytes == 0) ? v.e0 : v.e1;
                chk("o_data", 32'(a_if.o_data), 32'(exp_b));
                if (stall_left > 0) begin
                    a_if.i_ready = 1'b0;
                    stall_left--;
                end else begin
                    a_if.i_ready = 1'b1;
                    nbytes++;
                    if (nbytes == 2) begin
                        @(negedge clk);
                        chk("done_after_hs", 32'(a_done), 32'd1);
                        chk("dumping_in_done", 32'(a_dump), 32'd0);
                        go_a = v.go_mid;
                        @(negedge clk);
                        go_a = 1'b0;
                        chk("done_one_cycle", 32'(a_done), 32'd0);
                        chk("dumping_after", 32'(a_dump), 32'd0);
                        @(negedge clk);
                        chk("idle_no_restart", 32'(a_rd_en), 32'd0);
                        chk("idle_no_dump", 32'(a_dump), 32'd0);
                        fin = 1'b1;
                    end
                end
            end else begin
                a_if.i_ready = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        go_a = 1'b0;
        chk("finished_in_budget", 32'(fin), 32'd1);
        chk("strobe_count", 32'(strobes), 32'd15);
        chk("byte_count", 32'(nbytes), 32'd2);
    endtask

    initial begin
        int  nb;
        bit  hit;
        bit  seen;
        int  strobes;

        // pattern, stall, go_mid, byte0, byte1
        vecs[0] = '{15'h7FFF, 0, 1'b0, 8'hFF, 8'h7F};
        vecs[1] = '{15'h2AAA, 0, 1'b0, 8'hAA, 8'h2A};
        vecs[2] = '{15'h2AAA, 4, 1'b0, 8'hAA, 8'h2A};
        vecs[3] = '{15'h2AAA, 0, 1'b1, 8'hAA, 8'h2A};
        vecs[4] = '{15'h0001, 0, 1'b0, 8'h01, 8'h00};
        vecs[5] = '{15'h4000, 2, 1'b1, 8'h00, 8'h40};

        a_if.i_ready = 1'b1;
        b_if.i_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_dumping", 32'(a_dump), 32'd0);
        chk("rst_rd_en", 32'(a_rd_en), 32'd0);
        chk("rst_valid", 32'(a_if.o_valid), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_data", 32'(a_if.o_data), 32'd0);
        chk("rst_xy", 32'({a_x, a_y}), 32'd0);

        for (int i = 0; i < 6; i++) run_a(vecs[i]);

        // Reset during the fetch of the first cell of the second byte
        mem_a = 15'h7FFF;
        a_if.i_ready = 1'b1;
        @(negedge clk); go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        nb  = 0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (nb == 1 && a_rd_en) begin
                hit = 1'b1;
            end else begin
                if (a_if.o_valid) nb++;
                @(negedge clk);
            end
        end
        chk("reached_fetch2", 32'(hit), 32'd1);
        chk("fetch2_x", 32'(a_x), 32'd3);
        chk("fetch2_y", 32'(a_y), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dumping", 32'(a_dump), 32'd0);
        chk("midrst_rd_en", 32'(a_rd_en), 32'd0);
        chk("midrst_valid", 32'(a_if.o_valid), 32'd0);
        chk("midrst_done", 32'(a_done), 32'd0);
        chk("midrst_data", 32'(a_if.o_data), 32'd0);
        chk("midrst_xy", 32'({a_x, a_y}), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_done || a_rd_en || a_if.o_valid) seen = 1'b1;
        end
        chk("midrst_quiet", 32'(seen), 32'd0);
        run_a(vecs[0]);

        // 8x2 field, all ones: exactly two 0xFF bytes
        nb      = 0;
        strobes = 0;
        seen    = 1'b0;
        @(negedge clk); go_b = 1'b1;
        @(negedge clk); go_b = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (b_rd_en) begin
                chk("b_rd_xy", 32'({b_y, b_x}), 32'(strobes));
                strobes++;
            end
            if (b_if.o_valid) begin
                chk("b_data", 32'(b_if.o_data), 32'hFF);
                nb++;
            end
            if (b_done) seen = 1'b1;
            @(negedge clk);
        end
        chk("b_done_seen", 32'(seen), 32'd1);
        chk("b_byte_count", 32'(nb), 32'd2);
        chk("b_strobe_count", 32'(strobes), 32'd16);
        chk("b_idle_after", 32'({b_dump, b_if.o_valid, b_done}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
